// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multiport register file.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one busy flag per register, set by reserve, cleared by writes.
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [(1<<ADDR_W)-1:0] clr_vec,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(1<<ADDR_W)-1:0] busy_vec,
  output logic [(1<<ADDR_W)-1:0] busy_next
);

  // Reserve is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_next = busy_vec & ~clr_vec;
    if (rsv_en && (rsv_addr != '0)) busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy_vec <= '0;
    else        busy_vec <= busy_next;
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with registered reads and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-first collision data; default is read-first.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_val  [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W-1:0] rd_idx  [NUM_RD];
  logic [DATA_W-1:0] rd_next [NUM_RD];

  // Later ports overwrite earlier ones, so the highest-index port owns a conflict.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) wr_val[i] = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != '0)) begin
        wr_hit[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) mem[i] <= wr_val[i];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx[p]  = rd_addr[p*ADDR_W +: ADDR_W];
      rd_next[p] = mem[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit[rd_idx[p]]) rd_next[p] = wr_val[rd_idx[p]];
`endif
      if (rd_idx[p] == '0) rd_next[p] = '0;
    end
  end

  // rd_busy samples the post-update scoreboard so it matches busy_vec next cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
        rd_busy[p]                  <= busy_next[rd_idx[p]];
      end
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr_vec   (wr_hit),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses, port p at [p*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, NUM_RD*DATA_W, registered read data per port.
REQ-009 SHALL have port rd_busy, output, NUM_RD, registered scoreboard-pending flag per read port.
REQ-010 SHALL have port wr_en, input, NUM_WR, per-port write enable.
REQ-011 SHALL have port wr_addr, input, NUM_WR*ADDR_W, packed write addresses.
REQ-012 SHALL have port wr_data, input, NUM_WR*DATA_W, packed write data.
REQ-013 SHALL have port rsv_en, input, 1, reserve request: mark rsv_addr pending.
REQ-014 SHALL have port rsv_addr, input, ADDR_W, address to reserve.
REQ-015 SHALL have port busy_vec, output, 2**ADDR_W, current scoreboard state, bit i = register i pending.

Function
REQ-016 SHALL sample rd_addr each rising edge and present rd_data/rd_busy for it the next cycle (latency 1); outputs hold between edges.
REQ-017 SHALL write wr_data[w] to register wr_addr[w] on the rising edge when wr_en[w]=1.
REQ-018 SHALL, when several write ports target the same address in one cycle, commit the highest-index port only.
REQ-019 SHALL ignore writes, reserves and clears to address 0; register 0 reads as 0 with busy 0 always.
REQ-020 SHALL set busy[rsv_addr] on the edge when rsv_en=1, and clear busy[a] on the edge any enabled write targets a.
REQ-021 SHALL, on reserve and write to the same address in one cycle, leave busy set (reserve wins; new producer pending).
REQ-022 SHALL, on a read of an address being written the same cycle, return per REQ-035/036; rd_busy reflects busy_vec after that edge's update.
REQ-023 SHALL drive busy_vec directly from scoreboard flops (no combinational path from inputs).
REQ-024 SHALL treat all read ports as independent; any number may read the same address.

Reset
REQ-025 SHALL, while RST_N=0, clear all registers to 0, all busy bits to 0, rd_data to 0, rd_busy to 0, regardless of CLK.
REQ-026 SHALL discard any write or reserve presented on the edge coinciding with RST_N=0.
REQ-027 SHALL resume normal operation on the first rising edge after RST_N deasserts; first valid rd_data one cycle later.

Configuration
REQ-035 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to rd_data (write-first; highest write port wins per REQ-018).
REQ-036 SHALL, without REGFILE_BYPASS_EN, return the pre-write register value on a same-cycle read/write collision (read-first).
REQ-037 SHALL affect only collision data; scoreboard behaviour is identical in both builds.

Structure
REQ-038 SHALL place default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and a regfile address typedef in shared package regfile_pkg.
REQ-039 SHALL implement the scoreboard (REQ-020/021/023) as sub-module regfile_scoreboard; storage and read ports remain in multiport_regfile.

Verification
REQ-040 SHALL check reset: drive RST_N=0 mid-run after writing r5=0xDEADBEEF -> rd_data=0, busy_vec=0, later read r5 -> 0x00000000.
REQ-041 SHALL check dual-write conflict: wr_en=2'b11, both addr 7, data 0x11/0x22 -> r7 reads 0x22 one cycle after read.
REQ-042 SHALL check r0: write 0xFFFFFFFF to 0, reserve 0 -> read r0 = 0, busy_vec[0]=0.
REQ-043 SHALL check collision: write r3=0xA5A5A5A5 while reading r3 (old 0x1) -> rd_data 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000001 without.
REQ-044 SHALL check scoreboard: reserve r9 -> busy_vec[9]=1 next cycle; read r9 -> rd_busy=1; write r9 -> busy clears; reserve+write r9 same cycle -> busy stays 1.
REQ-045 SHALL check parameter sweep NUM_RD=4, NUM_WR=1, DATA_W=64, ADDR_W=4: random writes vs. reference model, all ports match each cycle.
